// File: rtl/uart_rx_os_pkg.sv
// Shared UART constants, receiver state codes, frame record and the 3-sample majority vote.
// The transmitter side packs frames with the same constants.
package uart_rx_os_pkg;

   localparam int UART_FRAME_BITS = 11;
   localparam int UART_DATA_BITS  = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_PAR   = 3'd3,
      ST_STOP  = 3'd4
   } rx_state_e;

   typedef struct packed {
      logic [UART_DATA_BITS-1:0] data;
      logic                      perr;
      logic                      ferr;
   } rx_frame_t;

   function automatic logic maj3(input logic [2:0] s);
      return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter for the UART receiver: flags the bit centre (mid) and the
// final clock of the bit (last). Held at zero while the receiver is idle.
module uart_bit_timer #(
   parameter int CMSB = 12
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          run,
   input  logic [CMSB:0] div,
   output logic          mid,
   output logic          last
);

   localparam logic [CMSB:0] CNT_ONE = {{CMSB{1'b0}}, 1'b1};

   logic [CMSB:0] cnt;
   logic [CMSB:0] half;

   assign half = div >> 1;
   assign mid  = (cnt == half);
   assign last = (cnt == (div - CNT_ONE));

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt <= '0;
      end else if (!run || last) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_ONE;
      end
   end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling single-clock UART receiver: 11-bit frames, even parity over data+parity,
// 3-sample majority at each bit centre, one-entry valid/ready output with sticky overrun.
module uart_rx_os
   import uart_rx_os_pkg::*;
#(
   parameter int CMSB = 12
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          en,
   input  logic [CMSB:0] div,
   input  logic          rx,
   output logic [7:0]    rdata,
   output logic          rvalid,
   input  logic          rready,
   output logic          perr,
   output logic          ferr,
   output logic          ovr,
   input  logic          ovr_clr,
   output logic          busy,
   output logic [2:0]    cst
);

   rx_state_e state_q, state_d;

   logic       sync1, rx_s, rx_s_d;
   logic [2:0] sh;
   logic       maj;
   logic       mid, last;
   logic [2:0] bitidx;
   logic [7:0] shreg;
   logic       par_bit;
   logic       deliver;
   rx_frame_t  out_q;
   logic       rvalid_q;
   logic       ovr_q;

   // Synchronizer and sample history; reset to the idle-high line level.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         sync1  <= 1'b1;
         rx_s   <= 1'b1;
         rx_s_d <= 1'b1;
         sh     <= 3'b111;
      end else begin
         sync1  <= rx;
         rx_s   <= sync1;
         rx_s_d <= rx_s;
         sh     <= {sh[1:0], rx_s};
      end
   end

   assign maj = maj3(sh);

   uart_bit_timer #(.CMSB(CMSB)) u_timer (
      .clk  (clk),
      .rstn (rstn),
      .run  (state_q != ST_IDLE),
      .div  (div),
      .mid  (mid),
      .last (last)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      deliver = 1'b0;
      case (state_q)
         ST_IDLE:  if (en && rx_s_d && !rx_s) state_d = ST_START;
         ST_START: begin
            if (mid && maj)  state_d = ST_IDLE;
            else if (last)   state_d = ST_DATA;
         end
         ST_DATA:  if (last && bitidx == 3'd7) state_d = ST_PAR;
         ST_PAR:   if (last) state_d = ST_STOP;
         ST_STOP: begin
            if (mid) begin
               state_d = ST_IDLE;
               deliver = 1'b1;
            end
         end
         default:  state_d = ST_IDLE;
      endcase
      if (!en) begin
         state_d = ST_IDLE;
         deliver = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         bitidx  <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
      end else begin
         bitidx <= (state_q == ST_DATA) ? (last ? bitidx + 3'd1 : bitidx) : 3'd0;
         if (state_q == ST_DATA && mid) shreg <= {maj, shreg[7:1]};
         if (state_q == ST_PAR && mid)  par_bit <= maj;
      end
   end

   // A full output register drops the new frame; otherwise load, even on a same-cycle take.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         out_q    <= '0;
         rvalid_q <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         if (deliver && !(rvalid_q && !rready)) begin
            out_q.data <= shreg;
            out_q.perr <= (^shreg) != par_bit;
            out_q.ferr <= ~maj;
            rvalid_q   <= 1'b1;
         end else if (rvalid_q && rready) begin
            rvalid_q <= 1'b0;
         end
         if (deliver && rvalid_q && !rready) ovr_q <= 1'b1;
         else if (ovr_clr)                   ovr_q <= 1'b0;
      end
   end

   assign rdata  = out_q.data;
   assign perr   = out_q.perr;
   assign ferr   = out_q.ferr;
   assign rvalid = rvalid_q;
   assign ovr    = ovr_q;
   assign busy   = (state_q != ST_IDLE);
   assign cst    = state_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: directed scenarios plus a randomized frame stream
// checked against a frame-level reference model.
module tb_uart_rx_os;

   localparam int CMSB = 12;

   logic          clk = 1'b0;
   logic          rstn, en, rx, rready, ovr_clr;
   logic [CMSB:0] div;
   logic [7:0]    rdata;
   logic          rvalid, perr, ferr, ovr, busy;
   logic [2:0]    cst;

   typedef struct {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
   } frame_t;

   frame_t got_q[$];
   frame_t exp_q[$];
   int     tests_run = 0;
   int     tests_failed = 0;
   int     cyc = 0;
   int     last_rise = -1;
   logic   rv_prev = 1'b0;

   uart_rx_os #(.CMSB(CMSB)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .en      (en),
      .div     (div),
      .rx      (rx),
      .rdata   (rdata),
      .rvalid  (rvalid),
      .rready  (rready),
      .perr    (perr),
      .ferr    (ferr),
      .ovr     (ovr),
      .ovr_clr (ovr_clr),
      .busy    (busy),
      .cst     (cst)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: log every accepted frame and the cycle of each rvalid rise.
   always begin
      @(negedge clk);
      #2;
      if (rvalid && rready) got_q.push_back('{rdata, perr, ferr});
      if (rvalid && !rv_prev) last_rise = cyc;
      rv_prev = rvalid;
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: a frame is a parity error when data+parity hold an odd number of ones.
   function automatic frame_t model_frame(input logic [7:0] d, input logic p, input logic s);
      frame_t f;
      f.data = d;
      f.perr = ($countones({d, p}) % 2) != 0;
      f.ferr = (s == 1'b0);
      return f;
   endfunction

   // Drives one frame starting at a negedge; t0 is the clk where sync1 captures the start bit.
   task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                             input int gap, output int t0);
      logic [10:0] f;
      f  = {s, p, d, 1'b0};
      t0 = 0;
      for (int i = 0; i < 11; i++) begin
         rx = f[i];
         if (i == 0) t0 = cyc + 1;
         repeat (int'(div)) @(negedge clk);
      end
      rx = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   task automatic wait_frames(input int n);
      for (int i = 0; i < 400 && got_q.size() < n; i++) @(negedge clk);
   endtask

   task automatic test_reset();
      rstn = 1'b0; en = 1'b1; rx = 1'b1; rready = 1'b1; ovr_clr = 1'b0; div = 16;
      repeat (3) @(negedge clk);
      tests_run++;
      if ({rdata, rvalid, perr, ferr, ovr, busy} !== 13'd0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %h expected 0", {rdata, rvalid, perr, ferr, ovr, busy});
      end
      tests_run++;
      if (cst !== 3'd0) begin
         tests_failed++;
         $display("FAIL reset_cst: got %0d expected 0", cst);
      end
      rstn = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_basic();
      int t0;
      got_q.delete();
      last_rise = -1;
      div = 16;
      send_frame(8'hA5, 1'b0, 1'b1, 6, t0);
      tests_run++;
      if (last_rise !== t0 + 171) begin
         tests_failed++;
         $display("FAIL basic_latency: rvalid rose at %0d expected %0d", last_rise, t0 + 171);
      end
      tests_run++;
      if (got_q.size() !== 1) begin
         tests_failed++;
         $display("FAIL basic_pulse: accepted-cycle count %0d expected 1", got_q.size());
      end else begin
         tests_run++;
         if ({got_q[0].data, got_q[0].perr, got_q[0].ferr} !== {8'hA5, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL basic_frame: got %h/%b/%b expected a5/0/0",
                     got_q[0].data, got_q[0].perr, got_q[0].ferr);
         end
      end
      tests_run++;
      if (rvalid !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_rvalid_low: got %b expected 0", rvalid);
      end
   endtask

   task automatic test_parity();
      int     t0;
      frame_t e;
      got_q.delete();
      e = model_frame(8'h3C, 1'b1, 1'b1);
      send_frame(8'h3C, 1'b1, 1'b1, 6, t0);
      wait_frames(1);
      tests_run++;
      if (got_q.size() != 1) begin
         tests_failed++;
         $display("FAIL parity_count: got %0d frames expected 1", got_q.size());
      end else begin
         tests_run++;
         if ({got_q[0].data, got_q[0].perr, got_q[0].ferr} !== {e.data, e.perr, e.ferr}) begin
            tests_failed++;
            $display("FAIL parity_frame: got %h/%b/%b expected %h/%b/%b",
                     got_q[0].data, got_q[0].perr, got_q[0].ferr, e.data, e.perr, e.ferr);
         end
      end
   endtask

   task automatic test_framing();
      int     t0;
      frame_t e0, e1;
      got_q.delete();
      e0 = model_frame(8'h00, 1'b0, 1'b0);
      e1 = model_frame(8'h55, 1'b0, 1'b1);
      send_frame(8'h00, 1'b0, 1'b0, 4, t0);
      send_frame(8'h55, 1'b0, 1'b1, 6, t0);
      wait_frames(2);
      tests_run++;
      if (got_q.size() != 2) begin
         tests_failed++;
         $display("FAIL framing_count: got %0d frames expected 2", got_q.size());
      end else begin
         tests_run++;
         if ({got_q[0].data, got_q[0].perr, got_q[0].ferr} !== {e0.data, e0.perr, e0.ferr}) begin
            tests_failed++;
            $display("FAIL framing_bad_stop: got %h/%b/%b expected %h/%b/%b",
                     got_q[0].data, got_q[0].perr, got_q[0].ferr, e0.data, e0.perr, e0.ferr);
         end
         tests_run++;
         if ({got_q[1].data, got_q[1].perr, got_q[1].ferr} !== {e1.data, e1.perr, e1.ferr}) begin
            tests_failed++;
            $display("FAIL framing_follow: got %h/%b/%b expected %h/%b/%b",
                     got_q[1].data, got_q[1].perr, got_q[1].ferr, e1.data, e1.perr, e1.ferr);
         end
      end
   endtask

   task automatic test_overflow();
      int t0;
      rready = 1'b0;
      send_frame(8'h11, 1'b0, 1'b1, 4, t0);
      send_frame(8'h22, 1'b0, 1'b1, 8, t0);
      tests_run++;
      if ({rvalid, rdata, ovr} !== {1'b1, 8'h11, 1'b1}) begin
         tests_failed++;
         $display("FAIL ovr_hold: got rvalid=%b rdata=%h ovr=%b expected 1/11/1", rvalid, rdata, ovr);
      end
      got_q.delete();
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      @(negedge clk);
      tests_run++;
      if (rvalid !== 1'b0) begin
         tests_failed++;
         $display("FAIL ovr_take: rvalid %b expected 0", rvalid);
      end
      tests_run++;
      if (got_q.size() != 1 || got_q[0].data !== 8'h11) begin
         tests_failed++;
         $display("FAIL ovr_taken_data: count %0d expected one frame of 11", got_q.size());
      end
      tests_run++;
      if (ovr !== 1'b1) begin
         tests_failed++;
         $display("FAIL ovr_sticky: got %b expected 1", ovr);
      end
      ovr_clr = 1'b1;
      @(negedge clk);
      ovr_clr = 1'b0;
      tests_run++;
      if (ovr !== 1'b0) begin
         tests_failed++;
         $display("FAIL ovr_clear: got %b expected 0", ovr);
      end
      rready = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_glitch();
      logic saw_busy;
      got_q.delete();
      saw_busy = 1'b0;
      div = 16;
      rx = 1'b0;
      repeat (5) @(negedge clk);
      rx = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (busy) saw_busy = 1'b1;
      end
      tests_run++;
      if (saw_busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL glitch_busy: busy pulse seen %b expected 1", saw_busy);
      end
      tests_run++;
      if ({busy, cst, rvalid} !== 5'd0) begin
         tests_failed++;
         $display("FAIL glitch_idle: busy=%b cst=%0d rvalid=%b expected 0/0/0", busy, cst, rvalid);
      end
      tests_run++;
      if (got_q.size() != 0) begin
         tests_failed++;
         $display("FAIL glitch_frames: got %0d frames expected 0", got_q.size());
      end
   endtask

   task automatic test_en_abort();
      int     t0;
      frame_t e;
      div = 16;
      rready = 1'b0;
      send_frame(8'h5A, 1'b0, 1'b1, 4, t0);
      got_q.delete();
      fork
         send_frame(8'h96, 1'b0, 1'b1, 0, t0);
         begin
            repeat (16 * 5 + 8) @(negedge clk);
            en = 1'b0;
            @(negedge clk);
            tests_run++;
            if ({cst, busy} !== 4'd0) begin
               tests_failed++;
               $display("FAIL abort_idle: cst=%0d busy=%b expected 0/0", cst, busy);
            end
         end
      join
      repeat (4) @(negedge clk);
      tests_run++;
      if ({rvalid, rdata, ovr} !== {1'b1, 8'h5A, 1'b0}) begin
         tests_failed++;
         $display("FAIL abort_held: rvalid=%b rdata=%h ovr=%b expected 1/5a/0", rvalid, rdata, ovr);
      end
      en = 1'b1;
      rready = 1'b1;
      repeat (3) @(negedge clk);
      got_q.delete();
      e = model_frame(8'hF0, 1'b0, 1'b1);
      send_frame(8'hF0, 1'b0, 1'b1, 6, t0);
      wait_frames(1);
      tests_run++;
      if (got_q.size() != 1) begin
         tests_failed++;
         $display("FAIL abort_next_count: got %0d frames expected 1", got_q.size());
      end else begin
         tests_run++;
         if ({got_q[0].data, got_q[0].perr, got_q[0].ferr} !== {e.data, e.perr, e.ferr}) begin
            tests_failed++;
            $display("FAIL abort_next_frame: got %h/%b/%b expected %h/%b/%b",
                     got_q[0].data, got_q[0].perr, got_q[0].ferr, e.data, e.perr, e.ferr);
         end
      end
   endtask

   task automatic test_back_to_back_random();
      int         t0, gap;
      logic [7:0] d;
      logic       p, s;
      got_q.delete();
      exp_q.delete();
      for (int n = 0; n < 24; n++) begin
         div = CMSB'(0) + $urandom_range(8, 40);
         d   = 8'($urandom);
         p   = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
         s   = ($urandom_range(0, 4) != 0);
         gap = s ? $urandom_range(0, 3) : $urandom_range(3, 6);
         exp_q.push_back(model_frame(d, p, s));
         send_frame(d, p, s, gap, t0);
      end
      wait_frames(exp_q.size());
      tests_run++;
      if (got_q.size() != exp_q.size()) begin
         tests_failed++;
         $display("FAIL random_count: got %0d frames expected %0d", got_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            tests_run++;
            if ({got_q[i].data, got_q[i].perr, got_q[i].ferr} !==
                {exp_q[i].data, exp_q[i].perr, exp_q[i].ferr}) begin
               tests_failed++;
               $display("FAIL random_frame_%0d: got %h/%b/%b expected %h/%b/%b", i,
                        got_q[i].data, got_q[i].perr, got_q[i].ferr,
                        exp_q[i].data, exp_q[i].perr, exp_q[i].ferr);
            end
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_parity();
      test_framing();
      test_overflow();
      test_glitch();
      test_en_abort();
      test_back_to_back_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
